// File: rtl/oled_iic_arbiter_if.sv
// Requester/IIC-driver bundle for the OLED IIC write arbiter.
// master = the arbiter side, slave = requesters plus IIC driver.
interface oled_iic_arbiter_if;
    logic [3:0]  req;
    logic [95:0] req_data;
    logic [3:0]  done;
    logic [3:0]  grant;
    logic        iic_write_req;
    logic [23:0] iic_write_data;
    logic        iic_write_done;
    logic        busy;
    logic        timeout_err;

    modport master (
        input  req, req_data, iic_write_done,
        output done, grant, iic_write_req, iic_write_data, busy, timeout_err
    );

    modport slave (
        output req, req_data, iic_write_done,
        input  done, grant, iic_write_req, iic_write_data, busy, timeout_err
    );
endinterface

// File: rtl/oled_iic_arbiter.sv
// Round-robin arbiter sharing one IIC write driver among four requesters,
// with a per-transaction completion timeout.
//
// state     | meaning
// S_IDLE    | no owner; pick the next requester round-robin
// S_ISSUE   | one-cycle write strobe to the IIC driver
// S_WAIT    | waiting for iic_write_done or the timeout
// S_RELEASE | done pulse (if completed); grant drops at the end
module oled_iic_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input logic             sys_clk,
    input logic             rst_n,
    oled_iic_arbiter_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

    localparam logic [31:0] TC_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [1:0]  last_grant;
    logic [31:0] timeout_cnt;
    logic [1:0]  winner;
    logic [1:0]  cand;
    logic [23:0] win_word;

    // Walk offsets from far to near so the nearest requester after last_grant wins.
    always_comb begin
        winner = last_grant;
        cand   = last_grant;
        for (int i = 4; i >= 1; i--) begin
            cand = last_grant + 2'(i);
            if (bus.req[cand]) winner = cand;
        end
    end

    assign win_word = bus.req_data[7'(winner) * 7'd24 +: 24];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            last_grant         <= 2'd3;
            timeout_cnt        <= '0;
            bus.grant          <= '0;
            bus.done           <= '0;
            bus.iic_write_req  <= 1'b0;
            bus.iic_write_data <= '0;
            bus.busy           <= 1'b0;
            bus.timeout_err    <= 1'b0;
        end else begin
            bus.iic_write_req <= 1'b0;
            bus.done          <= '0;
            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        state              <= S_ISSUE;
                        bus.grant          <= 4'b0001 << winner;
                        bus.iic_write_data <= win_word;
                        last_grant         <= winner;
                        bus.iic_write_req  <= 1'b1;
                        bus.busy           <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state       <= S_WAIT;
                    timeout_cnt <= '0;
                end
                S_WAIT: begin
                    // Completion takes priority over a coincident timeout.
                    if (bus.iic_write_done) begin
                        bus.done <= bus.grant;
                        state    <= S_RELEASE;
                    end else if (timeout_cnt == TC_LAST) begin
                        bus.timeout_err <= 1'b1;
                        state           <= S_RELEASE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 32'd1;
                    end
                end
                S_RELEASE: begin
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_oled_iic_arbiter.sv
// Scoreboard bench for oled_iic_arbiter: stimulus queues expected strobes and
// done pulses, a negedge monitor pops and compares them as the DUT produces them.
module tb_oled_iic_arbiter;
    typedef struct packed {
        logic [3:0]  g;
        logic [23:0] d;
    } strobe_t;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   n_vec   = 0;
    int   n_bad   = 0;

    strobe_t     strobe_q[$];
    logic [3:0]  done_q[$];
    logic [23:0] held_data;
    logic        hold_v = 1'b0;

    oled_iic_arbiter_if bus ();

    oled_iic_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus.master)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every observed strobe/done must match the head of its queue.
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (bus.iic_write_req) begin
                if (strobe_q.size() == 0) chk("unexpected strobe", 1, 0);
                else begin
                    strobe_t e;
                    e = strobe_q.pop_front();
                    chk("strobe grant", 32'(bus.grant), 32'(e.g));
                    chk("strobe data", 32'(bus.iic_write_data), 32'(e.d));
                end
                held_data = bus.iic_write_data;
                hold_v    = 1'b1;
            end else if (bus.grant != 4'b0 && hold_v) begin
                chk("data stable", 32'(bus.iic_write_data), 32'(held_data));
            end
            if (bus.grant == 4'b0) hold_v = 1'b0;
            if (bus.done != 4'b0) begin
                if (done_q.size() == 0) chk("unexpected done", 32'(bus.done), 0);
                else chk("done value", 32'(bus.done), 32'(done_q.pop_front()));
            end
        end
    end

    task automatic set_word(input int idx, input logic [23:0] w);
        bus.req_data[idx*24 +: 24] = w;
    endtask

    task automatic expect_txn(input int idx, input logic [23:0] w, input bit with_done);
        strobe_t s;
        s.g = 4'b0001 << idx;
        s.d = w;
        strobe_q.push_back(s);
        if (with_done) done_q.push_back(4'b0001 << idx);
    endtask

    task automatic wait_strobe(input string name);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!bus.iic_write_req && n < 50);
        if (!bus.iic_write_req) chk({name, " strobe wait expired"}, 0, 1);
    endtask

    task automatic pulse_done();
        bus.iic_write_done = 1'b1;
        @(negedge sys_clk);
        bus.iic_write_done = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, " grant"}, 32'(bus.grant), 0);
        chk({name, " done"}, 32'(bus.done), 0);
        chk({name, " iic_write_req"}, 32'(bus.iic_write_req), 0);
        chk({name, " busy"}, 32'(bus.busy), 0);
        chk({name, " timeout_err"}, 32'(bus.timeout_err), 0);
        chk({name, " iic_write_data"}, 32'(bus.iic_write_data), 0);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        logic [23:0] rr_word[4];
        rr_word[0] = 24'h3C_00_10;
        rr_word[1] = 24'h3C_01_11;
        rr_word[2] = 24'h3C_02_22;
        rr_word[3] = 24'h3C_03_33;
        bus.req            = 4'b0;
        bus.req_data       = '0;
        bus.iic_write_done = 1'b0;
        do_reset();

        // Single request, completion 10 cycles after the strobe.
        set_word(0, 24'h78_00_AE);
        expect_txn(0, 24'h78_00_AE, 1);
        bus.req = 4'b0001;
        wait_strobe("single");
        repeat (10) @(negedge sys_clk);
        pulse_done();
        chk("single busy in release", 32'(bus.busy), 1);
        bus.req = 4'b0;
        @(negedge sys_clk);
        chk("single busy after", 32'(bus.busy), 0);
        chk("single grant after", 32'(bus.grant), 0);

        // Round robin from a fresh reset: 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 4; i++) set_word(i, rr_word[i]);
        bus.req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            expect_txn(t % 4, rr_word[t % 4], 1);
            wait_strobe("rr");
            repeat (2) @(negedge sys_clk);
            pulse_done();
            if (t == 4) bus.req = 4'b0;
        end
        repeat (2) @(negedge sys_clk);

        // Timeout: requester 2, no completion.
        expect_txn(2, rr_word[2], 0);
        bus.req = 4'b0100;
        wait_strobe("timeout");
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!bus.timeout_err && n < 40);
        chk("timeout latency", 32'(n), 17);
        bus.req = 4'b0;
        @(negedge sys_clk);
        chk("timeout busy after", 32'(bus.busy), 0);
        expect_txn(3, rr_word[3], 1);
        bus.req = 4'b1000;
        wait_strobe("post-timeout");
        repeat (3) @(negedge sys_clk);
        pulse_done();
        bus.req = 4'b0;
        chk("timeout_err sticky", 32'(bus.timeout_err), 1);
        @(negedge sys_clk);

        // Completion on the terminal timeout cycle.
        do_reset();
        expect_txn(0, rr_word[0], 1);
        bus.req = 4'b0001;
        wait_strobe("simul");
        repeat (16) @(negedge sys_clk);
        pulse_done();
        bus.req = 4'b0;
        chk("simul timeout_err", 32'(bus.timeout_err), 0);
        repeat (3) @(negedge sys_clk);
        pulse_done();
        repeat (2) @(negedge sys_clk);
        chk("spurious busy", 32'(bus.busy), 0);
        chk("spurious grant", 32'(bus.grant), 0);

        // Data stability: requester 2 rewrites its word after grant.
        set_word(2, 24'h3C_02_5A);
        expect_txn(2, 24'h3C_02_5A, 1);
        bus.req = 4'b0100;
        wait_strobe("stable");
        set_word(2, 24'h3C_02_A5);
        repeat (4) @(negedge sys_clk);
        pulse_done();
        chk("stable data in release", 32'(bus.iic_write_data), 32'h3C_02_5A);
        bus.req = 4'b0;
        @(negedge sys_clk);

        // Reset during WAIT aborts the transaction without a done pulse.
        expect_txn(3, rr_word[3], 0);
        bus.req = 4'b1000;
        wait_strobe("abort");
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        bus.req = 4'b0;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("abort no done after", 32'(bus.busy), 0);
        set_word(0, 24'h78_00_AF);
        expect_txn(0, 24'h78_00_AF, 1);
        bus.req = 4'b0001;
        wait_strobe("after-abort");
        repeat (2) @(negedge sys_clk);
        pulse_done();
        bus.req = 4'b0;
        repeat (4) @(negedge sys_clk);

        chk("strobe queue drained", 32'(strobe_q.size()), 0);
        chk("done queue drained", 32'(done_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/oled_iic_arbiter.md
OLED_IIC_ARBITER -- requirements
Module: oled_iic_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2_000_000: maximum sys_clk cycles the block waits for iic_write_done before abandoning a transaction.
REQ-002 sys_clk  input  1  system clock; all logic rising-edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req  input  4  write request per requester; level, held by requester until its done pulse.
REQ-005 req_data  input  96  requester n word = req_data[24n+23:24n]; format {slave addr[23:16], reg addr[15:8], data[7:0]}.
REQ-006 done  output  4  one-cycle completion pulse to requester n.
REQ-007 grant  output  4  one-hot owner of the IIC driver; all-zero when idle.
REQ-008 iic_write_req  output  1  one-cycle write strobe to the IIC driver.
REQ-009 iic_write_data  output  24  latched word presented to the IIC driver.
REQ-010 iic_write_done  input  1  one-cycle completion pulse from the IIC driver.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 timeout_err  output  1  sticky flag; set on any timeout.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT, RELEASE; encoding left to implementer.
REQ-014 IDLE: if req != 0, select winner round-robin, searching from (last_grant+1) mod 4 upward; last_grant resets to 3, so requester 0 wins first after reset; go to ISSUE.
REQ-015 On the IDLE->ISSUE edge: grant[winner] set; iic_write_data latches the winner's word; last_grant updated.
REQ-016 ISSUE lasts exactly one cycle: iic_write_req = 1; next state WAIT.
REQ-017 iic_write_data and grant stay stable from ISSUE through RELEASE; req_data changes in that window are ignored.
REQ-018 WAIT: 32-bit timeout counter starts at 0 on entry and increments every cycle.
REQ-019 WAIT, iic_write_done = 1: done[granted] pulses for one cycle in the next cycle (the RELEASE cycle); next state RELEASE.
REQ-020 WAIT, counter reaches TIMEOUT_CYCLES-1 without iic_write_done: timeout_err set; no done pulse; next state RELEASE.
REQ-021 iic_write_done and timeout in the same cycle: completion wins; done pulses; timeout_err unchanged.
REQ-022 RELEASE lasts one cycle: grant cleared at its end; next state IDLE. Consequence: at most one write every 4 cycles plus IIC time; a requester cannot re-win before seeing done.
REQ-023 Requester deasserts req during ISSUE/WAIT: the transaction still completes; done still pulses.
REQ-024 iic_write_done outside WAIT is ignored.
REQ-025 iic_write_req never asserts outside ISSUE; done is at most one-hot.
REQ-026 timeout_err clears only on reset.

Reset
REQ-027 While rst_n = 0: state IDLE, last_grant 3, counter 0; outputs grant, done, iic_write_req, busy, timeout_err = 0 and iic_write_data = 24'h0.
REQ-028 Reset asserted mid-transaction aborts it immediately; no done pulse is generated, during or after reset.

Verification
REQ-029 Single request: req = 4'b0001, word 24'h78_00_AE; iic_write_done 10 cycles after the strobe -> one iic_write_req pulse with data 24'h7800AE; done = 4'b0001 exactly one cycle after iic_write_done; busy falls 1 cycle later.
REQ-030 Round-robin: req = 4'b1111 held, every write completes -> grant order 0,1,2,3,0; no requester is skipped or granted twice in a row.
REQ-031 Timeout: TIMEOUT_CYCLES = 16, iic_write_done never arrives -> timeout_err = 1 at WAIT cycle 16; no done pulse; arbiter returns to IDLE and serves the next request.
REQ-032 Simultaneous events: iic_write_done arrives on the terminal timeout cycle -> done pulses and timeout_err stays 0. Spurious iic_write_done while in IDLE -> no output change.
REQ-033 Data stability: requester 2 changes its word after grant -> iic_write_data keeps the value latched at grant until RELEASE ends.
REQ-034 Reset during WAIT: all outputs 0 within the reset cycle; after release, req = 4'b0001 completes normally.
